// File: rtl/axi_lite_master.sv
// axi_lite_master: turns single-beat load/store requests into AXI4-Lite transactions,
// one outstanding at a time, returning read data or write completion with an error flag.
module axi_lite_master #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int STRB_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wen,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [STRB_W-1:0] req_wstrb,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] io_master_araddr,
    output logic              io_master_arvalid,
    input  logic              io_master_arready,
    input  logic [DATA_W-1:0] io_master_rdata,
    input  logic [1:0]        io_master_rresp,
    input  logic              io_master_rvalid,
    output logic              io_master_rready,
    output logic [ADDR_W-1:0] io_master_awaddr,
    output logic              io_master_awvalid,
    input  logic              io_master_awready,
    output logic [DATA_W-1:0] io_master_wdata,
    output logic [STRB_W-1:0] io_master_wstrb,
    output logic              io_master_wvalid,
    input  logic              io_master_wready,
    input  logic [1:0]        io_master_bresp,
    input  logic              io_master_bvalid,
    output logic              io_master_bready
);
    typedef enum logic [2:0] {IDLE, AR, R, W_ADDR, B, RSP} state_t;
    state_t state_q, state_d;
    logic arvalid_q, arvalid_d, rready_q, rready_d;
    logic awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
    logic aw_done_q, aw_done_d, w_done_q, w_done_d;
    logic rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
    logic [ADDR_W-1:0] araddr_q, araddr_d, awaddr_q, awaddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
    logic [STRB_W-1:0] wstrb_q, wstrb_d;
    logic aw_hs, w_hs;
    assign aw_hs = awvalid_q && io_master_awready;
    assign w_hs  = wvalid_q && io_master_wready;
    always_comb begin
        state_d     = state_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        bready_d    = bready_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = rsp_err_q;
        araddr_d    = araddr_q;
        awaddr_d    = awaddr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        rdata_d     = rdata_q;
        case (state_q)
            IDLE: if (req_valid) begin
                if (req_wen) begin
                    state_d   = W_ADDR;
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                    awaddr_d  = req_addr;
                    wdata_d   = req_wdata;
                    wstrb_d   = req_wstrb;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                end else begin
                    state_d   = AR;
                    arvalid_d = 1'b1;
                    araddr_d  = req_addr;
                end
            end
            AR: if (io_master_arready) begin
                arvalid_d = 1'b0;
                rready_d  = 1'b1;
                state_d   = R;
            end
            R: if (io_master_rvalid) begin
                rdata_d     = io_master_rdata;
                rsp_err_d   = |io_master_rresp;
                rready_d    = 1'b0;
                rsp_valid_d = 1'b1;
                state_d     = RSP;
            end
            W_ADDR: begin
                // each channel retires on its own handshake; B waits for both
                if (aw_hs) begin
                    awvalid_d = 1'b0;
                    aw_done_d = 1'b1;
                end
                if (w_hs) begin
                    wvalid_d = 1'b0;
                    w_done_d = 1'b1;
                end
                if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
                    bready_d = 1'b1;
                    state_d  = B;
                end
            end
            B: if (io_master_bvalid) begin
                rsp_err_d   = |io_master_bresp;
                bready_d    = 1'b0;
                rsp_valid_d = 1'b1;
                state_d     = RSP;
            end
            RSP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            araddr_q    <= '0;
            awaddr_q    <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            bready_q    <= bready_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            araddr_q    <= araddr_d;
            awaddr_q    <= awaddr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            rdata_q     <= rdata_d;
        end
    end
    assign req_ready         = state_q == IDLE;
    assign rsp_valid         = rsp_valid_q;
    assign rsp_rdata         = rdata_q;
    assign rsp_err           = rsp_err_q;
    assign io_master_araddr  = araddr_q;
    assign io_master_arvalid = arvalid_q;
    assign io_master_rready  = rready_q;
    assign io_master_awaddr  = awaddr_q;
    assign io_master_awvalid = awvalid_q;
    assign io_master_wdata   = wdata_q;
    assign io_master_wstrb   = wstrb_q;
    assign io_master_wvalid  = wvalid_q;
    assign io_master_bready  = bready_q;
endmodule

// File: tb/tb_axi_lite_master.sv
// tb_axi_lite_master: directed table, hand-built corner sequences and randomized
// transactions checked against a latency/data model of the request-response contract.
module tb_axi_lite_master;
    logic clk = 1'b0, rst = 1'b1;
    logic req_valid = 1'b0, req_wen = 1'b0;
    logic req_ready, rsp_valid, rsp_err;
    logic [31:0] req_addr = '0, req_wdata = '0, rsp_rdata;
    logic [7:0] req_wstrb = '0;
    logic [31:0] io_master_araddr, io_master_awaddr, io_master_wdata;
    logic [31:0] io_master_rdata = '0;
    logic [7:0] io_master_wstrb;
    logic [1:0] io_master_rresp = '0, io_master_bresp = '0;
    logic io_master_arvalid, io_master_rready, io_master_awvalid, io_master_wvalid, io_master_bready;
    logic io_master_arready = 1'b0, io_master_rvalid = 1'b0, io_master_awready = 1'b0;
    logic io_master_wready = 1'b0, io_master_bvalid = 1'b0;
    int checks = 0, errors = 0;
    logic [31:0] last_rd;

    always #5 clk = ~clk;

    axi_lite_master #(.ADDR_W(32), .DATA_W(32), .STRB_W(8)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .io_master_araddr(io_master_araddr), .io_master_arvalid(io_master_arvalid),
        .io_master_arready(io_master_arready), .io_master_rdata(io_master_rdata),
        .io_master_rresp(io_master_rresp), .io_master_rvalid(io_master_rvalid),
        .io_master_rready(io_master_rready), .io_master_awaddr(io_master_awaddr),
        .io_master_awvalid(io_master_awvalid), .io_master_awready(io_master_awready),
        .io_master_wdata(io_master_wdata), .io_master_wstrb(io_master_wstrb),
        .io_master_wvalid(io_master_wvalid), .io_master_wready(io_master_wready),
        .io_master_bresp(io_master_bresp), .io_master_bvalid(io_master_bvalid),
        .io_master_bready(io_master_bready)
    );

    // slave delays count cycles a valid/ready is seen before the partner responds;
    // exp_lat counts cycles with the acceptance cycle as cycle 0
    typedef struct {
        logic        wen;
        logic [31:0] addr, wdata, rdata;
        logic [7:0]  wstrb;
        logic [1:0]  resp;
        int          ar_dly, r_dly, aw_dly, w_dly, b_dly;
        int          exp_lat;
        logic        exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic wen, input logic [31:0] addr, wdata, input logic [7:0] wstrb,
                                input logic [31:0] rdata, input logic [1:0] resp,
                                input int ar, r, aw, w, b, lat, input logic err, input logic [31:0] rd);
        vec_t v;
        v.wen = wen; v.addr = addr; v.wdata = wdata; v.wstrb = wstrb; v.rdata = rdata; v.resp = resp;
        v.ar_dly = ar; v.r_dly = r; v.aw_dly = aw; v.w_dly = w; v.b_dly = b;
        v.exp_lat = lat; v.exp_err = err; v.exp_rdata = rd;
        return v;
    endfunction

    task automatic run_txn(input vec_t v);
        int ar_n = 0, r_n = 0, aw_n = 0, w_n = 0, b_n = 0;
        bit got = 1'b0, ar_hs = 1'b0, aw_hs = 1'b0, w_hs = 1'b0;
        logic p_arv = 1'b0, p_arr = 1'b0, p_awv = 1'b0, p_awr = 1'b0, p_wv = 1'b0, p_wr = 1'b0;
        chk("idle_ready", 32'(req_ready), 1);
        req_valid = 1'b1; req_wen = v.wen; req_addr = v.addr; req_wdata = v.wdata; req_wstrb = v.wstrb;
        @(posedge clk); #1;
        req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom; req_wstrb = 8'($urandom);
        for (int c = 1; c <= 300 && !got; c++) begin
            chk("busy_ready", 32'(req_ready), 0);
            if (p_arv && !p_arr) chk("arvalid_drop", 32'(io_master_arvalid), 1);
            if (p_awv && !p_awr) chk("awvalid_drop", 32'(io_master_awvalid), 1);
            if (p_wv && !p_wr) chk("wvalid_drop", 32'(io_master_wvalid), 1);
            chk("valid_reassert", 32'((io_master_arvalid && ar_hs) || (io_master_awvalid && aw_hs) ||
                (io_master_wvalid && w_hs)), 0);
            chk("rready_in_ar", 32'(io_master_rready && io_master_arvalid), 0);
            chk("wrong_channel", 32'(v.wen ? (io_master_arvalid || io_master_rready)
                : (io_master_awvalid || io_master_wvalid || io_master_bready)), 0);
            if (io_master_arvalid) chk("araddr", io_master_araddr, v.addr);
            if (io_master_awvalid) chk("awaddr", io_master_awaddr, v.addr);
            if (io_master_wvalid) begin
                chk("wdata", io_master_wdata, v.wdata);
                chk("wstrb", 32'(io_master_wstrb), 32'(v.wstrb));
            end
            if (rsp_valid) begin
                got = 1'b1;
                chk("latency", c, v.exp_lat);
                chk("rsp_rdata", rsp_rdata, v.exp_rdata);
                chk("rsp_err", 32'(rsp_err), 32'(v.exp_err));
                {io_master_arready, io_master_rvalid, io_master_awready, io_master_wready, io_master_bvalid} = '0;
            end else begin
                io_master_arready = io_master_arvalid && ar_n == v.ar_dly;
                // stray rvalid while the address phase is still open must be ignored
                io_master_rvalid  = io_master_rready ? (r_n == v.r_dly) : (io_master_arvalid && 1'($urandom_range(1)));
                io_master_rdata   = (io_master_rready && r_n == v.r_dly) ? v.rdata : $urandom;
                io_master_rresp   = (io_master_rready && r_n == v.r_dly) ? v.resp : 2'($urandom);
                io_master_awready = io_master_awvalid && io_master_wvalid && aw_n == v.aw_dly;
                io_master_wready  = io_master_wvalid && w_n == v.w_dly;
                io_master_bvalid  = io_master_bready && b_n == v.b_dly;
                io_master_bresp   = io_master_bvalid ? v.resp : 2'($urandom);
            end
            p_arv = io_master_arvalid; p_arr = io_master_arready;
            p_awv = io_master_awvalid; p_awr = io_master_awready;
            p_wv = io_master_wvalid; p_wr = io_master_wready;
            ar_hs |= p_arv && p_arr; aw_hs |= p_awv && p_awr; w_hs |= p_wv && p_wr;
            if (io_master_arvalid) ar_n++;
            if (io_master_rready) r_n++;
            if (io_master_awvalid) aw_n++;
            if (io_master_wvalid) w_n++;
            if (io_master_bready) b_n++;
            @(posedge clk); #1;
        end
        chk("rsp_seen", 32'(got), 1);
        chk("rsp_one_pulse", 32'(rsp_valid), 0);
        chk("back_to_idle", 32'(req_ready), 1);
    endtask

    vec_t tbl[8];
    vec_t v;

    initial begin
        tbl[0] = mk(0, 32'h80000010, 32'h0, 8'h00, 32'hDEADBEEF, 2'd0, 0, 0, 0, 0, 0, 3, 0, 32'hDEADBEEF);
        tbl[1] = mk(1, 32'h80000020, 32'h12345678, 8'h0F, 32'h0, 2'd0, 0, 0, 0, 0, 0, 3, 0, 32'hDEADBEEF);
        tbl[2] = mk(1, 32'h80000024, 32'hCAFEF00D, 8'hF0, 32'h0, 2'd0, 0, 0, 0, 3, 0, 6, 0, 32'hDEADBEEF);
        tbl[3] = mk(0, 32'h80000030, 32'h0, 8'h00, 32'h0BADF00D, 2'd2, 0, 0, 0, 0, 0, 3, 1, 32'h0BADF00D);
        tbl[4] = mk(1, 32'h80000034, 32'h11223344, 8'hFF, 32'h0, 2'd0, 0, 0, 0, 0, 0, 3, 0, 32'h0BADF00D);
        tbl[5] = mk(0, 32'h80000040, 32'h0, 8'h00, 32'h55AA55AA, 2'd0, 10, 0, 0, 0, 0, 13, 0, 32'h55AA55AA);
        tbl[6] = mk(1, 32'h80000044, 32'hA0B0C0D0, 8'h3C, 32'h0, 2'd3, 0, 0, 1, 2, 2, 7, 1, 32'h55AA55AA);
        tbl[7] = mk(0, 32'h80000048, 32'h0, 8'h00, 32'h13579BDF, 2'd1, 2, 4, 0, 0, 0, 9, 1, 32'h13579BDF);

        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_ready", 32'(req_ready), 1);
        chk("rst_handshake_outs", 32'({io_master_arvalid, io_master_rready, io_master_awvalid,
            io_master_wvalid, io_master_bready, rsp_valid, rsp_err}), 0);
        chk("rst_rdata", rsp_rdata, 0);
        chk("rst_araddr", io_master_araddr, 0);
        chk("rst_awaddr", io_master_awaddr, 0);
        chk("rst_wdata", io_master_wdata, 0);
        chk("rst_wstrb", 32'(io_master_wstrb), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) run_txn(tbl[i]);
        last_rd = 32'h13579BDF;

        begin : back_to_back
            int n = 0, t1 = -1, t2 = -1, aw_first = -1;
            req_valid = 1'b1; req_wen = 1'b0; req_addr = 32'h80000090;
            @(posedge clk); #1;
            req_wen = 1'b1; req_addr = 32'h80000094; req_wdata = 32'h0F0F0F0F; req_wstrb = 8'h81;
            for (int c = 1; c <= 12; c++) begin
                if (rsp_valid) begin
                    n++;
                    if (n == 1) t1 = c; else t2 = c;
                    chk("b2b_rdata", rsp_rdata, 32'hA5A50001);
                    chk("b2b_err", 32'(rsp_err), 0);
                    chk("b2b_no_accept_in_rsp", 32'(req_ready), 0);
                end
                if (io_master_awvalid && aw_first < 0) begin
                    aw_first = c;
                    req_valid = 1'b0;
                    chk("b2b_awaddr", io_master_awaddr, 32'h80000094);
                end
                io_master_arready = io_master_arvalid;
                io_master_rvalid  = io_master_rready;
                io_master_rdata   = 32'hA5A50001;
                io_master_rresp   = 2'd0;
                io_master_awready = io_master_awvalid && io_master_wvalid;
                io_master_wready  = io_master_wvalid;
                io_master_bvalid  = io_master_bready;
                io_master_bresp   = 2'd0;
                @(posedge clk); #1;
            end
            {io_master_arready, io_master_rvalid, io_master_awready, io_master_wready, io_master_bvalid} = '0;
            chk("b2b_pulses", n, 2);
            chk("b2b_first_rsp", t1, 3);
            chk("b2b_write_accept", aw_first, 5);
            chk("b2b_second_rsp", t2, 7);
            last_rd = 32'hA5A50001;
        end

        for (int i = 0; i < 40; i++) begin
            v.wen = 1'($urandom_range(1));
            v.addr = $urandom; v.wdata = $urandom; v.rdata = $urandom;
            v.wstrb = 8'($urandom); v.resp = 2'($urandom_range(3));
            v.ar_dly = $urandom_range(4); v.r_dly = $urandom_range(4);
            v.w_dly = $urandom_range(4); v.aw_dly = $urandom_range(v.w_dly); v.b_dly = $urandom_range(4);
            v.exp_lat = v.wen ? 3 + (v.aw_dly > v.w_dly ? v.aw_dly : v.w_dly) + v.b_dly
                              : 3 + v.ar_dly + v.r_dly;
            if (!v.wen) last_rd = v.rdata;
            v.exp_rdata = last_rd;
            v.exp_err = v.resp != 2'd0;
            run_txn(v);
        end

        req_valid = 1'b1; req_wen = 1'b1; req_addr = 32'h800000A0; req_wdata = 32'h77777777; req_wstrb = 8'hFF;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("rst_mid_wvalid", 32'(io_master_wvalid), 1);
        io_master_awready = 1'b1; io_master_wready = 1'b1;
        @(posedge clk); #1;
        io_master_awready = 1'b0; io_master_wready = 1'b0;
        chk("rst_mid_in_b", 32'(io_master_bready), 1);
        rst = 1'b1; io_master_bvalid = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; io_master_bvalid = 1'b0;
        chk("rst_mid_outs", 32'({io_master_arvalid, io_master_rready, io_master_awvalid,
            io_master_wvalid, io_master_bready}), 0);
        chk("rst_mid_req_ready", 32'(req_ready), 1);
        chk("rst_mid_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_mid_rdata", rsp_rdata, 0);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            chk("rst_mid_quiet", 32'({rsp_valid, io_master_awvalid, io_master_bready}), 0);
        end
        run_txn(mk(1, 32'h800000B0, 32'h89ABCDEF, 8'h0C, 32'h0, 2'd0, 0, 0, 0, 1, 1, 5, 0, 32'h0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/axi_lite_master.md
Name: axi_lite_master

Overview:
- Upstream neighbour of the AXI slave memory port.
- Converts single-beat load/store requests from the CPU LSU/IFU side into AXI4-Lite read or write transactions on the io_master_* channels.
- Returns read data or write completion, plus an error flag, to the requester.
- One outstanding transaction at a time.
- The io_master_* outputs connect directly to the slave's io_slave_* inputs.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- STRB_W, 8, write-strobe width, matching the slave's wstrb port.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_wen  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  DATA_W  store data.
- req_wstrb  in  STRB_W  byte enables.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  DATA_W  load data; valid only with rsp_valid when the request was a read.
- rsp_err  out  1  resp != 0 on the completing channel.
- io_master_araddr  out  ADDR_W;  io_master_arvalid  out  1;  io_master_arready  in  1.
- io_master_rdata  in  DATA_W;  io_master_rresp  in  2;  io_master_rvalid  in  1;  io_master_rready  out  1.
- io_master_awaddr  out  ADDR_W;  io_master_awvalid  out  1;  io_master_awready  in  1.
- io_master_wdata  out  DATA_W;  io_master_wstrb  out  STRB_W;  io_master_wvalid  out  1;  io_master_wready  in  1.
- io_master_bresp  in  2;  io_master_bvalid  in  1;  io_master_bready  out  1.

Behaviour:
- Clock and reset: single clock clk; rst is synchronous, active-high. All outputs are registered except req_ready.
- Reset values:
  - FSM = IDLE.
  - All valid/ready outputs = 0; rsp_err = 0.
  - rsp_rdata, addresses, wdata, wstrb = 0.
  - Reset mid-transaction aborts immediately: all channel valids drop in the cycle after the rst edge, and no rsp_valid is produced.
- req_ready = (state == IDLE), combinational.
- Acceptance: on req_valid && req_ready, latch addr, wdata, wstrb and wen.
- FSM states:
  - IDLE:
    - On a read request, go to AR with arvalid=1 and araddr=req_addr, starting the next cycle.
    - On a write request, go to W_ADDR with awvalid=1 and wvalid=1 together, awaddr/wdata/wstrb driven from the request.
  - AR: hold arvalid and araddr stable until arvalid && arready. On that edge, drop arvalid, set rready=1 and go to R.
  - R:
    - Hold rready=1. On rvalid && rready, capture rdata into rsp_rdata and rsp_err = (rresp != 0).
    - Drop rready and go to RSP.
    - rvalid arriving in the same cycle as the AR handshake is not accepted; rready is only asserted in R.
  - W_ADDR:
    - awvalid and wvalid deassert independently: each drops on the edge where its own ready is sampled high, and neither is reasserted.
    - awvalid=1 is held until awready, and wvalid=1 until wready. awready and wready may arrive in the same or different cycles, in either order; the slave only raises awready while wvalid is also high.
    - When both handshakes have completed (tracked by aw_done/w_done flags), set bready=1 and go to B.
  - B: hold bready=1. On bvalid && bready, set rsp_err = (bresp != 0), drop bready and go to RSP.
  - RSP: rsp_valid=1 for exactly one cycle, then IDLE. rsp_rdata is unchanged on writes.
- Handshake rules: no valid is ever deasserted before its handshake. Address and data are held stable while valid is high.
- Minimum latency from acceptance edge to rsp_valid:
  - read: 3 cycles (arready and rvalid each high on first sample).
  - write: 3 cycles (awready and wready together on first sample, then bvalid on first sample).
- Back-to-back: a new request can be accepted in the cycle after rsp_valid, i.e. in IDLE. There is no acceptance during RSP.
- There is no timeout: the block waits indefinitely for slave ready/valid.

Test Plan:
- Read: req addr=0x80000010, slave returns rdata=0xDEADBEEF, rresp=0 -> araddr=0x80000010 held until arready; rsp_valid pulses once with rsp_rdata=0xDEADBEEF, rsp_err=0.
- Write with split handshakes: addr=0x80000020, wdata=0x12345678, wstrb=0x0F; awready and wready in the same cycle, then wready withheld 3 cycles on a second write -> wvalid stays high until wready, awvalid drops after its own handshake; single rsp_valid after bvalid; rsp_err=0.
- Error response: read with rresp=2'b10 -> rsp_err=1; a following write with bresp=0 -> rsp_err=0.
- Stalled slave: arready withheld 10 cycles -> arvalid=1 and araddr stable throughout; req_ready=0; no rsp_valid until after the R handshake.
- Back-to-back: read then write issued with req_valid held high -> second accepted only in the cycle after the first rsp_valid; exactly two rsp_valid pulses.
- Reset mid-write: assert rst while in B -> next cycle all io_master valid/ready outputs = 0, state IDLE, req_ready=1, no rsp_valid.
